// File: rtl/perf_bus_pkg.sv
// rtl/perf_bus_pkg.sv - shared types and constants for the peripheral bus arbiter
package perf_bus_pkg;

    localparam int PERF_ADDR_W      = 64;
    localparam int PERF_DATA_W      = 64;
    localparam int PERF_TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/perf_bus_arbiter_if.sv
// rtl/perf_bus_arbiter_if.sv - request/response and peripheral bus bundle
// master modport: arbiter side (takes requests, drives the shared bus)
// slave modport : environment side (requesters and peripheral decoder)
interface perf_bus_arbiter_if
    import perf_bus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = PERF_ADDR_W,
    parameter int DATA_W  = PERF_DATA_W
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_wren;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic                      rsp_err;
    logic [ADDR_W-1:0]         perf_addr_out;
    logic [DATA_W-1:0]         perf_data_out;
    logic                      perf_wren;
    logic                      perf_en;
    logic                      perf_ack;
    logic [DATA_W-1:0]         perf_rdata;

    modport master (
        input  req_valid, req_addr, req_data, req_wren, perf_ack, perf_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err,
               perf_addr_out, perf_data_out, perf_wren, perf_en
    );

    modport slave (
        output req_valid, req_addr, req_data, req_wren, perf_ack, perf_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err,
               perf_addr_out, perf_data_out, perf_wren, perf_en
    );
endinterface

// File: rtl/perf_rr_pick.sv
// rtl/perf_rr_pick.sv - round-robin pick: first set request at or above pointer, with wrap
// Ports: i_req (request vector), i_ptr (search start), o_idx (winner), o_any (any request set)
module perf_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);
    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [IDX_W:0]       w_sum;

    // Rotating the doubled vector right by the pointer puts request (ptr+k) mod N at bit k.
    assign w_dbl = {i_req, i_req} >> i_ptr;
    assign w_rot = w_dbl[NUM_REQ-1:0];

    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        w_sum = '0;
        // Walk downward so the lowest rotated position (closest to the pointer) wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_sum = {1'b0, i_ptr} + (IDX_W + 1)'(k);
                if (w_sum >= (IDX_W + 1)'(NUM_REQ)) begin
                    w_sum = w_sum - (IDX_W + 1)'(NUM_REQ);
                end
                o_idx = w_sum[IDX_W-1:0];
                o_any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/perf_bus_arbiter.sv
// rtl/perf_bus_arbiter.sv - round-robin arbiter sharing one peripheral bus among NUM_REQ requesters
// Ports: clk, rst (async, active-high), bus (perf_bus_arbiter_if.master: requests, responses, peripheral bus)
// Optional macro PERF_ARB_TIMEOUT_EN: ack watchdog aborting WAIT after TIMEOUT cycles with rsp_err.
module perf_bus_arbiter
    import perf_bus_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = PERF_ADDR_W,
    parameter int DATA_W  = PERF_DATA_W,
    parameter int TIMEOUT = PERF_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    perf_bus_arbiter_if.master bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    arb_state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0]     r_ptr, w_ptr_nxt;
    logic [IDX_W-1:0]     r_gnt, w_gnt_nxt;
    logic [ADDR_W-1:0]    r_addr, w_addr_nxt;
    logic [DATA_W-1:0]    r_data, w_data_nxt;
    logic                 r_wren, w_wren_nxt;

    // Every output is a register loaded with the value the next state must present.
    logic [NUM_REQ-1:0]   r_req_ready, w_req_ready_nxt;
    logic [NUM_REQ-1:0]   r_rsp_valid, w_rsp_valid_nxt;
    logic [DATA_W-1:0]    r_rsp_data, w_rsp_data_nxt;
    logic [ADDR_W-1:0]    r_paddr, w_paddr_nxt;
    logic [DATA_W-1:0]    r_pdata, w_pdata_nxt;
    logic                 r_pwren, w_pwren_nxt;
    logic                 r_pen, w_pen_nxt;

    logic [IDX_W-1:0]     w_pick;
    logic                 w_any;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_data;
    logic                 w_sel_wren;

`ifdef PERF_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic                 r_rsp_err, w_rsp_err_nxt;
`endif

    perf_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .i_req (bus.req_valid),
        .i_ptr (r_ptr),
        .o_idx (w_pick),
        .o_any (w_any)
    );

    // Constant-index mux of the winning requester's fields.
    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_wren = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick == IDX_W'(i)) begin
                w_sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = bus.req_data[i*DATA_W +: DATA_W];
                w_sel_wren = bus.req_wren[i];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_gnt_nxt       = r_gnt;
        w_addr_nxt      = r_addr;
        w_data_nxt      = r_data;
        w_wren_nxt      = r_wren;
        w_req_ready_nxt = '0;
        w_rsp_valid_nxt = '0;
        w_rsp_data_nxt  = '0;
        w_paddr_nxt     = '0;
        w_pdata_nxt     = '0;
        w_pwren_nxt     = 1'b0;
        w_pen_nxt       = 1'b0;
`ifdef PERF_ARB_TIMEOUT_EN
        w_cnt_nxt       = r_cnt;
        w_rsp_err_nxt   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt     = ST_ISSUE;
                    w_gnt_nxt       = w_pick;
                    w_addr_nxt      = w_sel_addr;
                    w_data_nxt      = w_sel_data;
                    w_wren_nxt      = w_sel_wren;
                    w_req_ready_nxt = ONE << w_pick;
                    w_pen_nxt       = 1'b1;
                    w_paddr_nxt     = w_sel_addr;
                    w_pdata_nxt     = w_sel_data;
                    w_pwren_nxt     = w_sel_wren;
`ifdef PERF_ARB_TIMEOUT_EN
                    w_cnt_nxt       = '0;
`endif
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (bus.perf_ack) begin
                    w_state_nxt     = ST_RESP;
                    w_rsp_valid_nxt = ONE << r_gnt;
                    w_rsp_data_nxt  = r_wren ? '0 : bus.perf_rdata;
                end
`ifdef PERF_ARB_TIMEOUT_EN
                else if (r_state == ST_WAIT && r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt     = ST_RESP;
                    w_rsp_valid_nxt = ONE << r_gnt;
                    w_rsp_err_nxt   = 1'b1;
                end
`endif
                else begin
                    w_state_nxt = ST_WAIT;
                    w_paddr_nxt = r_addr;
                    w_pdata_nxt = r_data;
                    w_pwren_nxt = r_wren;
`ifdef PERF_ARB_TIMEOUT_EN
                    if (r_state == ST_WAIT) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
`endif
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = (r_gnt == IDX_W'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_wren      <= 1'b0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
            r_paddr     <= '0;
            r_pdata     <= '0;
            r_pwren     <= 1'b0;
            r_pen       <= 1'b0;
`ifdef PERF_ARB_TIMEOUT_EN
            r_cnt       <= '0;
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_gnt       <= w_gnt_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_wren      <= w_wren_nxt;
            r_req_ready <= w_req_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_paddr     <= w_paddr_nxt;
            r_pdata     <= w_pdata_nxt;
            r_pwren     <= w_pwren_nxt;
            r_pen       <= w_pen_nxt;
`ifdef PERF_ARB_TIMEOUT_EN
            r_cnt       <= w_cnt_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
`endif
        end
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_data      = r_rsp_data;
    assign bus.perf_addr_out = r_paddr;
    assign bus.perf_data_out = r_pdata;
    assign bus.perf_wren     = r_pwren;
    assign bus.perf_en       = r_pen;
`ifdef PERF_ARB_TIMEOUT_EN
    assign bus.rsp_err       = r_rsp_err;
`else
    assign bus.rsp_err       = 1'b0;
`endif
endmodule

// File: tb/tb_perf_bus_arbiter.sv
// tb/tb_perf_bus_arbiter.sv - directed self-checking bench for perf_bus_arbiter
module tb_perf_bus_arbiter;
    localparam int NR = 2;
    localparam int AW = 64;
    localparam int DW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    perf_bus_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    perf_bus_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [AW+DW+DW+2*NR+4-1:0] all_outs();
        return {bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err,
                bus.perf_addr_out, bus.perf_data_out, bus.perf_wren, bus.perf_en};
    endfunction

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic w);
        bus.req_valid[i]           = v;
        bus.req_addr[i*AW +: AW]   = a;
        bus.req_data[i*DW +: DW]   = d;
        bus.req_wren[i]            = w;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (all_outs() !== '0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", all_outs());
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (all_outs() !== '0) begin
            bad++; $display("FAIL idle_after_reset got=%h exp=0", all_outs());
        end
    endtask

    task automatic test_single_write();
        set_req(0, 1'b1, 64'h0000_0000_2000_0001, 64'hDEAD_BEEF, 1'b1);
        bus.perf_ack = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.perf_en, bus.perf_wren, bus.req_ready, bus.rsp_valid} !== {1'b1, 1'b1, 2'b01, 2'b00}) begin
            bad++; $display("FAIL wr_issue_ctl got=%b%b%b%b exp=110100", bus.perf_en, bus.perf_wren, bus.req_ready, bus.rsp_valid);
        end
        total++;
        if (bus.perf_addr_out !== 64'h0000_0000_2000_0001 || bus.perf_data_out !== 64'hDEAD_BEEF) begin
            bad++; $display("FAIL wr_issue_bus got=%h/%h exp=2000_0001/DEADBEEF", bus.perf_addr_out, bus.perf_data_out);
        end
        bus.req_valid[0] = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, bus.req_ready, bus.perf_en, bus.rsp_err} !== {2'b01, 2'b00, 1'b0, 1'b0} || bus.rsp_data !== '0) begin
            bad++; $display("FAIL wr_resp got=%b%b%b%b data=%h exp=01000000 data=0", bus.rsp_valid, bus.req_ready, bus.perf_en, bus.rsp_err, bus.rsp_data);
        end
        total++;
        if (bus.perf_addr_out !== '0 || bus.perf_wren !== 1'b0) begin
            bad++; $display("FAIL wr_resp_bus_clear got=%h/%b exp=0/0", bus.perf_addr_out, bus.perf_wren);
        end
        bus.perf_ack = 1'b0;
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 2'b00) begin
            bad++; $display("FAIL wr_single_pulse got=%b exp=00", bus.rsp_valid);
        end
    endtask

    // Pointer is 1 here, so requester 1 gets the bus; ack sampled at the 6th edge after grant.
    task automatic test_read_delayed();
        int en_cnt = 0;
        set_req(1, 1'b1, 64'h0000_0000_0000_0ABC, 64'h5555, 1'b0);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.perf_en === 1'b1) en_cnt++;
            total++;
            if (bus.rsp_valid !== ((k == 6) ? 2'b10 : 2'b00)) begin
                bad++; $display("FAIL rd_rsp_valid_k%0d got=%b exp=%b", k, bus.rsp_valid, (k == 6) ? 2'b10 : 2'b00);
            end
            if (k < 6) begin
                total++;
                if (bus.perf_addr_out !== 64'h0ABC || bus.perf_wren !== 1'b0) begin
                    bad++; $display("FAIL rd_addr_hold_k%0d got=%h exp=abc", k, bus.perf_addr_out);
                end
            end
            if (k == 5) begin
                bus.perf_ack   = 1'b1;
                bus.perf_rdata = 64'h1234;
            end
        end
        total++;
        if (bus.rsp_data !== 64'h1234) begin
            bad++; $display("FAIL rd_rsp_data got=%h exp=1234", bus.rsp_data);
        end
        total++;
        if (en_cnt != 1) begin
            bad++; $display("FAIL rd_en_pulse got=%0d exp=1", en_cnt);
        end
        bus.perf_ack   = 1'b0;
        bus.perf_rdata = '0;
        @(negedge clk);
    endtask

    task automatic test_contention();
        int seq[$];
        int dbl = 0;
        set_req(0, 1'b1, 64'h100, 64'hA0, 1'b1);
        set_req(1, 1'b1, 64'h200, 64'hB1, 1'b1);
        bus.perf_ack = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if ($countones(bus.req_ready) > 1) dbl++;
            if (bus.req_ready == 2'b01) seq.push_back(0);
            if (bus.req_ready == 2'b10) seq.push_back(1);
        end
        bus.req_valid = '0;
        bus.perf_ack  = 1'b0;
        total++;
        if (dbl != 0) begin
            bad++; $display("FAIL rr_double_grant got=%0d exp=0", dbl);
        end
        total++;
        if (seq.size() != 4) begin
            bad++; $display("FAIL rr_grant_count got=%0d exp=4", seq.size());
        end else begin
            total++;
            if (seq[0] != 0 || seq[1] != 1 || seq[2] != 0 || seq[3] != 1) begin
                bad++; $display("FAIL rr_order got=%0d%0d%0d%0d exp=0101", seq[0], seq[1], seq[2], seq[3]);
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ack_idle();
        int seen = 0;
        bus.perf_ack   = 1'b1;
        bus.perf_rdata = 64'hFFFF;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid !== 2'b00 || bus.perf_en !== 1'b0 || bus.req_ready !== 2'b00) seen++;
        end
        bus.perf_ack = 1'b0;
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL idle_ack_ignored got=%0d exp=0", seen);
        end
        set_req(0, 1'b1, 64'h300, 64'h77, 1'b1);
        @(negedge clk);
        total++;
        if (bus.req_ready !== 2'b01 || bus.perf_en !== 1'b1) begin
            bad++; $display("FAIL idle_ack_then_grant got=%b/%b exp=01/1", bus.req_ready, bus.perf_en);
        end
        bus.req_valid[0] = 1'b0;
        bus.perf_ack     = 1'b1;
        @(negedge clk);
        bus.perf_ack = 1'b0;
        total++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_data !== '0) begin
            bad++; $display("FAIL idle_ack_resp got=%b/%h exp=01/0", bus.rsp_valid, bus.rsp_data);
        end
        @(negedge clk);
    endtask

    // Pointer is 1 here; requester 1 read with no ack.
    task automatic test_timeout();
        int hits = 0;
        set_req(1, 1'b1, 64'h400, 64'h0, 1'b0);
        bus.perf_rdata = 64'hBAD0;
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
`ifdef PERF_ARB_TIMEOUT_EN
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            total++;
            if (bus.rsp_valid !== ((k == 10) ? 2'b10 : 2'b00)) begin
                bad++; $display("FAIL to_rsp_valid_k%0d got=%b", k, bus.rsp_valid);
            end
        end
        total++;
        if (bus.rsp_err !== 1'b1 || bus.rsp_data !== '0) begin
            bad++; $display("FAIL to_err got=%b/%h exp=1/0", bus.rsp_err, bus.rsp_data);
        end
        bus.perf_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (bus.rsp_valid !== 2'b00 || bus.perf_en !== 1'b0) hits++;
        end
        bus.perf_ack = 1'b0;
        total++;
        if (hits != 0) begin
            bad++; $display("FAIL to_late_ack got=%0d exp=0", hits);
        end
`else
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 2'b00) hits++;
        end
        total++;
        if (hits != 0) begin
            bad++; $display("FAIL wait_hold got=%0d exp=0", hits);
        end
        bus.perf_ack   = 1'b1;
        bus.perf_rdata = 64'h55AA;
        @(negedge clk);
        bus.perf_ack = 1'b0;
        total++;
        if (bus.rsp_valid !== 2'b10 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 64'h55AA) begin
            bad++; $display("FAIL wait_long_resp got=%b/%b/%h exp=10/0/55aa", bus.rsp_valid, bus.rsp_err, bus.rsp_data);
        end
`endif
        repeat (2) @(negedge clk);
    endtask

    task automatic test_async_reset();
        int seen = 0;
        // Complete a requester-0 write so the pointer sits at 1 before the reset.
        set_req(0, 1'b1, 64'h500, 64'h1, 1'b1);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        bus.perf_ack     = 1'b1;
        @(negedge clk);
        bus.perf_ack = 1'b0;
        @(negedge clk);
        set_req(1, 1'b1, 64'h600, 64'h2, 1'b0);
        @(negedge clk);
        bus.req_valid[1] = 1'b0;
        @(negedge clk);
        total++;
        if (bus.perf_addr_out !== 64'h600) begin
            bad++; $display("FAIL ar_in_wait got=%h exp=600", bus.perf_addr_out);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (all_outs() !== '0) begin
            bad++; $display("FAIL ar_async_clear got=%h exp=0", all_outs());
        end
        @(negedge clk);
        rst = 1'b0;
        set_req(0, 1'b1, 64'h700, 64'h3, 1'b1);
        set_req(1, 1'b1, 64'h800, 64'h4, 1'b1);
        bus.perf_ack = 1'b1;
        @(negedge clk);
        total++;
        if (bus.req_ready !== 2'b01 || bus.perf_addr_out !== 64'h700) begin
            bad++; $display("FAIL ar_ptr_zero got=%b/%h exp=01/700", bus.req_ready, bus.perf_addr_out);
        end
        bus.req_valid = '0;
        @(negedge clk);
        bus.perf_ack = 1'b0;
        total++;
        if (bus.rsp_valid !== 2'b01) begin
            bad++; $display("FAIL ar_resp_after got=%b exp=01", bus.rsp_valid);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_valid !== 2'b00) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL ar_dropped got=%0d exp=0", seen);
        end
    endtask

    initial begin
        bus.req_valid  = '0;
        bus.req_addr   = '0;
        bus.req_data   = '0;
        bus.req_wren   = '0;
        bus.perf_ack   = 1'b0;
        bus.perf_rdata = '0;
        test_reset();
        test_single_write();
        test_read_delayed();
        test_contention();
        test_ack_idle();
        test_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
